// File: rtl/serv_serial_pkg.sv
// Shared definitions for the SERV Wishbone-to-serial bridge: frame layout,
// command byte bit positions and the bridge state encoding.
package serv_serial_pkg;

    localparam int FRAME_LEN    = 72;
    localparam int WORD_LEN     = 32;
    localparam int CMD_WE_BIT   = 7;
    localparam int CMD_DBUS_BIT = 6;
    localparam int BIT_CNT_W    = 7;
    localparam int DIV_CNT_W    = 8;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ACK,
        ST_GAP
    } bridgeState_e;

    // Command byte, address, then data slot (zero on MOSI for reads).
    function automatic logic [FRAME_LEN-1:0] buildFrame(
        input logic                we,
        input logic                isDbus,
        input logic [3:0]          sel,
        input logic [WORD_LEN-1:0] adr,
        input logic [WORD_LEN-1:0] dat
    );
        logic [7:0] cmd;
        cmd               = 8'h00;
        cmd[CMD_WE_BIT]   = we;
        cmd[CMD_DBUS_BIT] = isDbus;
        cmd[3:0]          = sel;
        return {cmd, adr, (we ? dat : {WORD_LEN{1'b0}})};
    endfunction

endpackage

// File: rtl/serial_shift_engine.sv
// Shifts one 72-bit frame out on MOSI (MSB first) while collecting MISO bits;
// owns the serial clock divider, bit counter and chip select timing.
module serial_shift_engine
    import serv_serial_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [FRAME_LEN-1:0] frame_i,
    output logic                 done_o,
    output logic [WORD_LEN-1:0]  rxWord_o,
    output logic                 serClk_o,
    output logic                 serCs_o,
    output logic                 serMosi_o,
    input  logic                 serMiso_i
);

    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(CLK_DIV - 1);

    logic                 active_q;
    logic                 highPhase_q;
    logic [DIV_CNT_W-1:0] divCnt_q;
    logic [BIT_CNT_W-1:0] bitCnt_q;
    logic [FRAME_LEN-1:0] shReg_q;
    logic [WORD_LEN-1:0]  rx_q;
    logic                 serClk_q;
    logic                 cs_q;

    logic phaseEnd;
    logic sampleNow;

    assign phaseEnd  = active_q && (divCnt_q == DIV_LAST);
    assign sampleNow = active_q && highPhase_q && (divCnt_q == '0);
    assign done_o    = phaseEnd && highPhase_q && (bitCnt_q == LAST_BIT);

    // With CLK_DIV=1 the final MISO sample lands on the same edge as done.
    assign rxWord_o  = sampleNow ? {rx_q[WORD_LEN-2:0], serMiso_i} : rx_q;

    assign serClk_o  = serClk_q;
    assign serCs_o   = cs_q;
    assign serMosi_o = shReg_q[FRAME_LEN-1];

    always_ff @(posedge clk) begin
        if (rst_i) begin
            active_q    <= 1'b0;
            highPhase_q <= 1'b0;
            divCnt_q    <= '0;
            bitCnt_q    <= '0;
            shReg_q     <= '0;
            rx_q        <= '0;
            serClk_q    <= 1'b0;
            cs_q        <= 1'b1;
        end else if (start_i) begin
            active_q    <= 1'b1;
            highPhase_q <= 1'b0;
            divCnt_q    <= '0;
            bitCnt_q    <= '0;
            shReg_q     <= frame_i;
            rx_q        <= '0;
            serClk_q    <= 1'b0;
            cs_q        <= 1'b0;
        end else if (active_q) begin
            if (sampleNow) begin
                rx_q <= {rx_q[WORD_LEN-2:0], serMiso_i};
            end
            if (phaseEnd) begin
                divCnt_q <= '0;
                if (!highPhase_q) begin
                    highPhase_q <= 1'b1;
                    serClk_q    <= 1'b1;
                end else if (bitCnt_q == LAST_BIT) begin
                    active_q    <= 1'b0;
                    highPhase_q <= 1'b0;
                    serClk_q    <= 1'b0;
                    cs_q        <= 1'b1;
                    shReg_q     <= '0;
                end else begin
                    highPhase_q <= 1'b0;
                    serClk_q    <= 1'b0;
                    bitCnt_q    <= bitCnt_q + BIT_CNT_W'(1);
                    shReg_q     <= {shReg_q[FRAME_LEN-2:0], 1'b0};
                end
            end else begin
                divCnt_q <= divCnt_q + DIV_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/serv_wb_serial_bridge.sv
// Bridges SERV's instruction and data Wishbone ports onto one serial link:
// arbitrates (dbus first), runs the IDLE/SHIFT/ACK/GAP sequence and drives the acks.
module serv_wb_serial_bridge
    import serv_serial_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic        o_ser_clk,
    output logic        o_ser_cs,
    output logic        o_ser_mosi,
    input  logic        i_ser_miso
);

    bridgeState_e          state_q;
    logic                  ownerDbus_q;
    logic                  isWrite_q;
    logic                  ibusAck_q;
    logic                  dbusAck_q;
    logic [WORD_LEN-1:0]   ibusRdt_q;
    logic [WORD_LEN-1:0]   dbusRdt_q;

    logic                  start_d;
    logic [FRAME_LEN-1:0]  frame_d;
    logic                  engDone;
    logic [WORD_LEN-1:0]   engRx;

    always_comb begin
        start_d = 1'b0;
        frame_d = '0;
        if (state_q == ST_IDLE) begin
            if (i_dbus_cyc) begin
                start_d = 1'b1;
                frame_d = buildFrame(i_dbus_we, 1'b1, i_dbus_sel, i_dbus_adr, i_dbus_dat);
            end else if (i_ibus_cyc) begin
                start_d = 1'b1;
                frame_d = buildFrame(1'b0, 1'b0, 4'hF, i_ibus_adr, 32'h0);
            end
        end
    end

    serial_shift_engine #(
        .CLK_DIV(CLK_DIV)
    ) u_engine (
        .clk       (clk),
        .rst_i     (i_rst),
        .start_i   (start_d),
        .frame_i   (frame_d),
        .done_o    (engDone),
        .rxWord_o  (engRx),
        .serClk_o  (o_ser_clk),
        .serCs_o   (o_ser_cs),
        .serMosi_o (o_ser_mosi),
        .serMiso_i (i_ser_miso)
    );

    // An abandoned request (cyc dropped mid-frame) gets no ack and leaves rdt alone.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            ownerDbus_q <= 1'b0;
            isWrite_q   <= 1'b0;
            ibusAck_q   <= 1'b0;
            dbusAck_q   <= 1'b0;
            ibusRdt_q   <= '0;
            dbusRdt_q   <= '0;
        end else begin
            ibusAck_q <= 1'b0;
            dbusAck_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_d) begin
                        ownerDbus_q <= i_dbus_cyc;
                        isWrite_q   <= i_dbus_cyc & i_dbus_we;
                        state_q     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (engDone) begin
                        state_q <= ST_ACK;
                        if (ownerDbus_q && i_dbus_cyc) begin
                            dbusAck_q <= 1'b1;
                            dbusRdt_q <= isWrite_q ? '0 : engRx;
                        end else if (!ownerDbus_q && i_ibus_cyc) begin
                            ibusAck_q <= 1'b1;
                            ibusRdt_q <= engRx;
                        end
                    end
                end
                ST_ACK:  state_q <= ST_GAP;
                ST_GAP:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_ibus_ack = ibusAck_q;
    assign o_dbus_ack = dbusAck_q;
    assign o_ibus_rdt = ibusRdt_q;
    assign o_dbus_rdt = dbusRdt_q;

endmodule

// File: tb/tb_serv_wb_serial_bridge.sv
// Randomized bench for serv_wb_serial_bridge with a cycle-timeline reference model,
// plus directed frames with literal expectations and a CLK_DIV=1 instance.
module tb_serv_wb_serial_bridge;

    localparam int D         = 2;
    localparam int FRAME_CYC = 144 * D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [31:0] iAdr = '0;
    logic        iCyc = 1'b0;
    logic [31:0] dAdr = '0, dDat = '0;
    logic [3:0]  dSel = '0;
    logic        dWe = 1'b0, dCyc = 1'b0;
    logic        miso = 1'b0;
    logic [31:0] oIRdt, oDRdt;
    logic        oIAck, oDAck, oClk, oCs, oMosi;

    serv_wb_serial_bridge #(.CLK_DIV(D)) dut (
        .clk(clk), .i_rst(rst),
        .i_ibus_adr(iAdr), .i_ibus_cyc(iCyc), .o_ibus_rdt(oIRdt), .o_ibus_ack(oIAck),
        .i_dbus_adr(dAdr), .i_dbus_dat(dDat), .i_dbus_sel(dSel), .i_dbus_we(dWe),
        .i_dbus_cyc(dCyc), .o_dbus_rdt(oDRdt), .o_dbus_ack(oDAck),
        .o_ser_clk(oClk), .o_ser_cs(oCs), .o_ser_mosi(oMosi), .i_ser_miso(miso)
    );

    logic        rst1 = 1'b1;
    logic [31:0] iAdr1 = '0;
    logic        iCyc1 = 1'b0;
    logic        miso1 = 1'b0;
    logic [31:0] oIRdt1, oDRdt1;
    logic        oIAck1, oDAck1, oClk1, oCs1, oMosi1;

    serv_wb_serial_bridge #(.CLK_DIV(1)) dut1 (
        .clk(clk), .i_rst(rst1),
        .i_ibus_adr(iAdr1), .i_ibus_cyc(iCyc1), .o_ibus_rdt(oIRdt1), .o_ibus_ack(oIAck1),
        .i_dbus_adr(32'h0), .i_dbus_dat(32'h0), .i_dbus_sel(4'h0), .i_dbus_we(1'b0),
        .i_dbus_cyc(1'b0), .o_dbus_rdt(oDRdt1), .o_dbus_ack(oDAck1),
        .o_ser_clk(oClk1), .o_ser_cs(oCs1), .o_ser_mosi(oMosi1), .i_ser_miso(miso1)
    );

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference model: one transaction is a fixed timeline counted from its capture cycle.
    bit          chkEn = 0, rstChk = 0;
    bit          mActive = 0, mOwnerD = 0, mAckOk = 0;
    logic [71:0] mFrame = '0;
    logic [31:0] mResp = '0, eIRdt = '0, eDRdt = '0, nextResp = '0;
    bit          useNextResp = 0;
    int          mT0 = 0, mAckCyc = 0, mIdleFrom = 0;
    logic        eCs = 1'b1, eClk = 1'b0, eMosi = 1'b0, eIAck = 1'b0, eDAck = 1'b0, eMiso = 1'b0;
    int          n, n1, k, b;
    logic        cWe;
    logic [3:0]  cSel;
    logic [31:0] cAdr, cDat;

    always @(posedge clk) begin
        n     = cycle;
        n1    = cycle + 1;
        cycle = n1;
        if (rst) begin
            mActive   = 0;
            mAckOk    = 0;
            mIdleFrom = n1;
            eIRdt     = '0;
            eDRdt     = '0;
            chkEn     = 1;
            rstChk    = 1;
        end else begin
            if (mActive && n == mAckCyc - 1) begin
                mAckOk = mOwnerD ? dCyc : iCyc;
                if (mAckOk && mOwnerD) eDRdt = mFrame[71] ? 32'h0 : mResp;
                if (mAckOk && !mOwnerD) eIRdt = mResp;
            end
            if (mActive && n == mAckCyc) mActive = 0;
            if (!mActive && n >= mIdleFrom && (dCyc || iCyc)) begin
                mOwnerD = dCyc;
                cWe  = dCyc ? dWe : 1'b0;
                cSel = dCyc ? dSel : 4'hF;
                cAdr = dCyc ? dAdr : iAdr;
                cDat = cWe ? dDat : 32'h0;
                mFrame = {cWe, dCyc, 2'b00, cSel, cAdr, cDat};
                mResp  = useNextResp ? nextResp : $urandom;
                useNextResp = 0;
                mT0       = n;
                mAckCyc   = n + 1 + FRAME_CYC;
                mIdleFrom = mAckCyc + 2;
                mActive   = 1;
                mAckOk    = 0;
            end
        end
        eCs = 1'b1; eClk = 1'b0; eMosi = 1'b0; eIAck = 1'b0; eDAck = 1'b0;
        eMiso = 1'($urandom % 2);
        if (mActive && n1 >= mT0 + 1 && n1 <= mT0 + FRAME_CYC) begin
            k     = n1 - mT0 - 1;
            b     = k / (2 * D);
            eCs   = 1'b0;
            eClk  = ((k % (2 * D)) >= D);
            eMosi = mFrame[71 - b];
            if (b >= 40) eMiso = mResp[71 - b];
        end
        if (mActive && n1 == mAckCyc && mAckOk) begin
            eIAck = !mOwnerD;
            eDAck = mOwnerD;
        end
    end

    logic [71:0] colBits = '0, lastFrame = '0;
    int          colCnt = 0, lastCnt = 0;
    logic        prevClk = 1'b0, prevCs = 1'b1;

    always @(negedge clk) begin
        miso = eMiso;
        if (chkEn) begin
            checkOutput("serCs",   32'(oCs),   32'(eCs));
            checkOutput("serClk",  32'(oClk),  32'(eClk));
            checkOutput("serMosi", 32'(oMosi), 32'(eMosi));
            checkOutput("ibusAck", 32'(oIAck), 32'(eIAck));
            checkOutput("dbusAck", 32'(oDAck), 32'(eDAck));
            if (eIAck) checkOutput("ibusRdt", oIRdt, eIRdt);
            if (eDAck) checkOutput("dbusRdt", oDRdt, eDRdt);
            if (rstChk) begin
                checkOutput("ibusRdtAfterReset", oIRdt, 32'h0);
                checkOutput("dbusRdtAfterReset", oDRdt, 32'h0);
                rstChk = 0;
            end
        end
        if (!oCs && oClk && !prevClk) begin
            colBits = {colBits[70:0], oMosi};
            colCnt++;
        end
        if (oCs && !prevCs) begin
            lastFrame = colBits;
            lastCnt   = colCnt;
            colCnt    = 0;
        end
        prevClk = oClk;
        prevCs  = oCs;
    end

    // Serial slave for the CLK_DIV=1 instance, keyed only off its serial pins.
    logic [31:0] pat1 = 32'hA5A5_5A5A;
    int          hi1Cnt = 0, riseTotal1 = 0, r0 = 0, r1 = 0;
    logic        prevClk1 = 1'b0, prevCs1 = 1'b1;

    always @(negedge clk) begin
        if (oCs1) begin
            if (!prevCs1) riseTotal1 = hi1Cnt;
            hi1Cnt = 0;
        end else begin
            if (oClk1 && !prevClk1) begin
                if (hi1Cnt == 0) r0 = cycle;
                if (hi1Cnt == 1) r1 = cycle;
                hi1Cnt++;
            end
            if (!oClk1) miso1 = (hi1Cnt >= 40 && hi1Cnt < 72) ? pat1[71 - hi1Cnt] : 1'b0;
        end
        prevClk1 = oClk1;
        prevCs1  = oCs1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit toD, input bit we, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic [3:0] sel);
        if (toD) begin
            dWe = we; dAdr = adr; dDat = dat; dSel = sel; dCyc = 1'b1;
        end else begin
            iAdr = adr; iCyc = 1'b1;
        end
    endtask

    task automatic waitAck(input bit onD, output int at, output bit ok);
        ok = 0;
        at = 0;
        for (int i = 0; i < 1000; i++) begin
            if (onD ? oDAck : oIAck) begin
                at = cycle;
                ok = 1;
                return;
            end
            step();
        end
        total++;
        bad++;
        $display("[TB] FAIL ackTimeout: bus %0d got no ack within 1000 cycles, expected one", onD);
    endtask

    task automatic scrambleFields();
        iAdr = $urandom; dAdr = $urandom; dDat = $urandom;
        dSel = 4'($urandom); dWe = 1'($urandom);
    endtask

    int          c, at, at2, iQuit, dQuit, elapsed, mode;
    bit          ok, iPend, dPend, iHold, dHold, scramble, sawAck, done;
    logic [31:0] resp;

    initial begin
        repeat (3) step();
        rst = 1'b0;
        checkOutput("resetCs",   32'(oCs),   32'h1);
        checkOutput("resetClk",  32'(oClk),  32'h0);
        checkOutput("resetMosi", 32'(oMosi), 32'h0);
        checkOutput("resetAcks", {30'h0, oIAck, oDAck}, 32'h0);
        checkOutput("resetIRdt", oIRdt, 32'h0);
        step();

        nextResp = 32'h13; useNextResp = 1;
        applyStimulus(0, 0, 32'h10, 32'h0, 4'h0);
        c = cycle;
        waitAck(0, at, ok);
        if (ok) begin
            checkOutput("ibusLatency", 32'(at - c), 32'd289);
            checkOutput("ibusRdtLit",  oIRdt, 32'h13);
        end
        step();
        checkOutput("ibusAckOnePulse", 32'(oIAck), 32'h0);
        step();
        iCyc = 1'b0;
        step();
        checkOutput("noReissueCs", 32'(oCs), 32'h1);
        checkOutput("ibusCmdByte", 32'(lastFrame[71:64]), 32'h0F);
        checkOutput("ibusAdrBits", lastFrame[63:32], 32'h10);
        checkOutput("ibusDataSlot", lastFrame[31:0], 32'h0);
        checkOutput("ibusBitCount", 32'(lastCnt), 32'd72);

        applyStimulus(1, 1, 32'h8000_0004, 32'hDEAD_BEEF, 4'b0011);
        c = cycle;
        waitAck(1, at, ok);
        dCyc = 1'b0;
        if (ok) begin
            checkOutput("dbusLatency", 32'(at - c), 32'd289);
            checkOutput("dbusWriteRdt", oDRdt, 32'h0);
        end
        step(); step();
        checkOutput("dbusCmdByte", 32'(lastFrame[71:64]), 32'hC3);
        checkOutput("dbusAdrBits", lastFrame[63:32], 32'h8000_0004);
        checkOutput("dbusDataBits", lastFrame[31:0], 32'hDEAD_BEEF);

        applyStimulus(1, 0, 32'h0000_0100, 32'h0, 4'hF);
        applyStimulus(0, 0, 32'h0000_0200, 32'h0, 4'h0);
        c = cycle;
        waitAck(1, at, ok);
        dCyc = 1'b0;
        if (ok) begin
            checkOutput("bothDbusFirst", 32'(at - c), 32'd289);
            checkOutput("bothIbusWaits", 32'(oIAck), 32'h0);
        end
        step();
        checkOutput("bothFirstCmdDbus", 32'(lastFrame[70]), 32'h1);
        waitAck(0, at2, ok);
        iCyc = 1'b0;
        if (ok) checkOutput("bothIbusLatency", 32'(at2 - c), 32'd580);
        step();
        checkOutput("bothSecondCmdIbus", 32'(lastFrame[70]), 32'h0);
        step(); step();

        applyStimulus(0, 0, $urandom, 32'h0, 4'h0);
        c = cycle;
        while (cycle < c + 1 + 40 * 2 * D) step();
        rst = 1'b1;
        iCyc = 1'b0;
        step();
        rst = 1'b0;
        checkOutput("abortCs",   32'(oCs),   32'h1);
        checkOutput("abortIRdt", oIRdt, 32'h0);
        sawAck = 0;
        repeat (300) begin
            step();
            if (oIAck || oDAck) sawAck = 1;
        end
        checkOutput("abortNoAck", 32'(sawAck), 32'h0);
        resp = $urandom;
        nextResp = resp; useNextResp = 1;
        applyStimulus(0, 0, $urandom, 32'h0, 4'h0);
        c = cycle;
        waitAck(0, at, ok);
        iCyc = 1'b0;
        if (ok) begin
            checkOutput("freshLatency", 32'(at - c), 32'd289);
            checkOutput("freshRdt", oIRdt, resp);
        end
        step(); step();

        for (int it = 0; it < 12; it++) begin
            mode = $urandom_range(0, 2);
            scrambleFields();
            iPend = (mode != 1); dPend = (mode != 0);
            iCyc = iPend; dCyc = dPend;
            iHold = 1'($urandom); dHold = 1'($urandom);
            iQuit = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 400) : -1;
            dQuit = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 400) : -1;
            scramble = 1'($urandom);
            done = 0;
            for (elapsed = 1; elapsed <= 1500; elapsed++) begin
                step();
                if (scramble) scrambleFields();
                if (!iPend) iCyc = 1'b0;
                if (!dPend) dCyc = 1'b0;
                if (iPend && oIAck) begin iPend = 0; iCyc = iHold; end
                if (dPend && oDAck) begin dPend = 0; dCyc = dHold; end
                if (iPend && elapsed == iQuit) begin iPend = 0; iCyc = 1'b0; end
                if (dPend && elapsed == dQuit) begin dPend = 0; dCyc = 1'b0; end
                if (!iPend && !dPend && !iCyc && !dCyc && !mActive && cycle >= mIdleFrom) begin
                    done = 1;
                    break;
                end
            end
            if (!done) begin
                total++;
                bad++;
                $display("[TB] FAIL randomTimeout: iteration %0d did not finish in 1500 cycles", it);
                iCyc = 1'b0; dCyc = 1'b0;
            end
        end

        rst1 = 1'b0;
        step();
        checkOutput("div1ResetCs", 32'(oCs1), 32'h1);
        iAdr1 = $urandom;
        iCyc1 = 1'b1;
        c = cycle;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (oIAck1) begin ok = 1; at = cycle; break; end
            step();
        end
        iCyc1 = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL div1AckTimeout: no ack within 400 cycles");
        end else begin
            checkOutput("div1Latency", 32'(at - c), 32'd145);
            checkOutput("div1Rdt", oIRdt1, 32'hA5A5_5A5A);
            step();
            checkOutput("div1AckOnePulse", 32'(oIAck1), 32'h0);
            checkOutput("div1ClkPeriod", 32'(r1 - r0), 32'd2);
            checkOutput("div1BitCount", 32'(riseTotal1), 32'd72);
        end

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
